reg_file_mp: RTL and testbench

Parametrised multi-port register file for the MIPS datapath, the next generation of the single-cycle register file. It provides a configurable number of read ports and two write ports: port A for ALU/decode writeback and port B for late/multicycle load writeback. It adds optional write-to-read bypass, hardwired register 0, and a per-register pending-write scoreboard that lets the control unit stall on load-use hazards. It sits between decode (reads, scoreboard queries) and writeback (writes, scoreboard clears).

---
 rtl/reg_file_mp.sv | 114 +++++++++++
 tb/tb_reg_file_mp.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file_mp.sv
// Multi-port MIPS register file: NRD read ports, two write ports,
// optional bypass, hardwired r0 and a pending-load busy scoreboard.
module reg_file_mp #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*DW-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic              wa_en,
  input  logic [AW-1:0]     wa_addr,
  input  logic [DW-1:0]     wa_data,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DW-1:0]     wb_data,
  input  logic              bs_en,
  input  logic [AW-1:0]     bs_addr,
  output logic              any_busy,
  output logic [AW:0]       busy_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busy_nx;
  logic [AW:0]      cnt;
  logic             wa_ok;
  logic             wb_ok;
  logic             bs_ok;
  logic             inc;
  logic             dec;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  assign wa_ok = wa_en && !is_zero(wa_addr);
  assign wb_ok = wb_en && !is_zero(wb_addr);
  assign bs_ok = bs_en && !is_zero(bs_addr);

  // Array update; port A is applied last so it wins a same-address clash
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wb_ok) mem[wb_addr] <= wb_data;
      if (wa_ok) mem[wa_addr] <= wa_data;
    end
  end

  // Next busy vector: clear from late writeback, set from load issue wins
  always_comb begin
    busy_nx = busy;
    if (wb_ok) busy_nx[wb_addr] = 1'b0;
    if (bs_ok) busy_nx[bs_addr] = 1'b1;
  end

  // Count deltas derived from actual bit transitions, not from requests
  assign inc = bs_ok && !busy[bs_addr];
  assign dec = wb_ok && busy[wb_addr] &&
               !(bs_ok && (bs_addr == wb_addr));

  // Busy vector register
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) busy <= '0;
    else      busy <= busy_nx;
  end

  // Busy population count kept in step with the vector
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else begin
      unique case ({inc, dec})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : g_rd
      logic [AW-1:0] a;
      logic [DW-1:0] d;

      assign a = rd_addr[k*AW +: AW];

      // Array read with optional same-cycle forwarding, A over B
      always_comb begin
        d = mem[a];
        if (BYPASS != 0) begin
          if (wb_ok && (wb_addr == a)) d = wb_data;
          if (wa_ok && (wa_addr == a)) d = wa_data;
        end
        if (!rst || is_zero(a)) d = '0;
      end

      assign rd_data[k*DW +: DW] = d;
      assign rd_busy[k] = rst && busy[a] && !is_zero(a);
    end
  endgenerate

  assign any_busy = rst && (|busy);
  assign busy_cnt = rst ? cnt : '0;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: bypass and non-bypass copies
// driven in parallel from a vector table plus reset sequences.
module tb_reg_file_mp;

  logic        CLK = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [63:0] rd_data_n;
  logic [1:0]  rd_busy;
  logic [1:0]  rd_busy_n;
  logic        wa_en = 1'b0;
  logic [4:0]  wa_addr = '0;
  logic [31:0] wa_data = '0;
  logic        wb_en = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        bs_en = 1'b0;
  logic [4:0]  bs_addr = '0;
  logic        any_busy;
  logic        any_busy_n;
  logic [5:0]  busy_cnt;
  logic [5:0]  busy_cnt_n;

  int total = 0;
  int passed = 0;

  always #5 CLK = ~CLK;

  reg_file_mp dut (
    .CLK(CLK), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bs_en(bs_en), .bs_addr(bs_addr),
    .any_busy(any_busy), .busy_cnt(busy_cnt)
  );

  reg_file_mp #(.BYPASS(0)) dut_nb (
    .CLK(CLK), .rst(rst),
    .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .bs_en(bs_en), .bs_addr(bs_addr),
    .any_busy(any_busy_n), .busy_cnt(busy_cnt_n)
  );

  typedef struct {
    logic        wa_en;
    logic [4:0]  wa_addr;
    logic [31:0] wa_data;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        bs_en;
    logic [4:0]  bs_addr;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] ed0;
    logic [31:0] en0;
    logic [31:0] ed1;
    logic        eb0;
    logic [5:0]  ecnt;
    logic        eany;
  } vec_t;

  vec_t v [22];

  task automatic chk(input string name, input int idx,
                     input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic idle();
    wa_en = 1'b0;
    wb_en = 1'b0;
    bs_en = 1'b0;
  endtask

  task automatic read_all_zero(input string name);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'd0, 5'(a)};
      #1;
      chk({name, "_d"}, a, {32'd0, rd_data[31:0]}, 64'd0);
      chk({name, "_nd"}, a, {32'd0, rd_data_n[31:0]}, 64'd0);
      chk({name, "_b"}, a, {63'd0, rd_busy[0]}, 64'd0);
    end
  endtask

  initial begin
    v[0]  = '{1,5,32'hDEADBEEF,0,0,0,0,0, 5,5,
              32'hDEADBEEF,0,32'hDEADBEEF,0,0,0};
    v[1]  = '{0,0,0,0,0,0,0,0, 5,0,
              32'hDEADBEEF,32'hDEADBEEF,0,0,0,0};
    v[2]  = '{1,7,32'h11111111,1,7,32'h22222222,0,0, 7,7,
              32'h11111111,0,32'h11111111,0,0,0};
    v[3]  = '{0,0,0,0,0,0,0,0, 7,0,
              32'h11111111,32'h11111111,0,0,0,0};
    v[4]  = '{1,0,32'h1234,0,0,0,0,0, 0,0, 0,0,0,0,0,0};
    v[5]  = '{0,0,0,0,0,0,0,0, 0,5, 0,0,32'hDEADBEEF,0,0,0};
    v[6]  = '{0,0,0,1,3,32'h33,0,0, 3,3, 32'h33,0,32'h33,0,0,0};
    v[7]  = '{0,0,0,0,0,0,1,9, 9,3, 0,0,32'h33,0,0,0};
    v[8]  = '{0,0,0,1,9,32'hAA,1,9, 9,0, 32'hAA,0,0,1,1,1};
    v[9]  = '{0,0,0,1,9,32'hBB,0,0, 9,0, 32'hBB,32'hAA,0,1,1,1};
    v[10] = '{0,0,0,0,0,0,0,0, 9,0, 32'hBB,32'hBB,0,0,0,0};
    v[11] = '{0,0,0,1,9,32'hCC,1,9, 9,0, 32'hCC,32'hBB,0,0,0,0};
    v[12] = '{0,0,0,0,0,0,1,9, 9,0, 32'hCC,32'hCC,0,1,1,1};
    v[13] = '{0,0,0,0,0,0,0,0, 9,0, 32'hCC,32'hCC,0,1,1,1};
    v[14] = '{0,0,0,1,9,32'hDD,0,0, 9,0, 32'hDD,32'hCC,0,1,1,1};
    v[15] = '{0,0,0,0,0,0,0,0, 9,0, 32'hDD,32'hDD,0,0,0,0};
    v[16] = '{0,0,0,0,0,0,1,0, 0,0, 0,0,0,0,0,0};
    v[17] = '{0,0,0,0,0,0,0,0, 0,0, 0,0,0,0,0,0};
    v[18] = '{1,4,32'h44,0,0,0,1,4, 4,0, 32'h44,0,0,0,0,0};
    v[19] = '{0,0,0,0,0,0,0,0, 4,0, 32'h44,32'h44,0,1,1,1};
    v[20] = '{0,0,0,1,4,32'h45,0,0, 4,0, 32'h45,32'h44,0,1,1,1};
    v[21] = '{0,0,0,0,0,0,0,0, 4,0, 32'h45,32'h45,0,0,0,0};

    #2;
    chk("rst_cnt", 0, {58'd0, busy_cnt}, 64'd0);
    chk("rst_any", 0, {63'd0, any_busy}, 64'd0);
    @(negedge CLK);
    rst = 1'b1;
    read_all_zero("init");

    foreach (v[i]) begin
      @(negedge CLK);
      wa_en = v[i].wa_en; wa_addr = v[i].wa_addr; wa_data = v[i].wa_data;
      wb_en = v[i].wb_en; wb_addr = v[i].wb_addr; wb_data = v[i].wb_data;
      bs_en = v[i].bs_en; bs_addr = v[i].bs_addr;
      rd_addr = {v[i].r1, v[i].r0};
      #1;
      chk("d0", i, {32'd0, rd_data[31:0]}, {32'd0, v[i].ed0});
      chk("nb_d0", i, {32'd0, rd_data_n[31:0]}, {32'd0, v[i].en0});
      chk("d1", i, {32'd0, rd_data[63:32]}, {32'd0, v[i].ed1});
      chk("busy0", i, {63'd0, rd_busy[0]}, {63'd0, v[i].eb0});
      chk("cnt", i, {58'd0, busy_cnt}, {58'd0, v[i].ecnt});
      chk("any", i, {63'd0, any_busy}, {63'd0, v[i].eany});
    end

    // Three loads in flight, then reset mid-cycle
    for (int r = 1; r <= 3; r++) begin
      @(negedge CLK);
      bs_en = 1'b1; bs_addr = 5'(r);
      wa_en = 1'b1; wa_addr = 5'(r); wa_data = 32'(r);
    end
    @(negedge CLK);
    idle();
    rd_addr = {5'd3, 5'd2};
    #1;
    chk("pre_cnt", 0, {58'd0, busy_cnt}, 64'd3);
    chk("pre_d2", 0, {32'd0, rd_data[31:0]}, 64'd2);
    chk("pre_d3", 0, {32'd0, rd_data[63:32]}, 64'd3);
    chk("pre_b", 0, {62'd0, rd_busy}, 64'd3);

    wa_en = 1'b1; wa_addr = 5'd6; wa_data = 32'h66;
    rd_addr = {5'd1, 5'd6};
    #2;
    rst = 1'b0;
    #1;
    chk("rst_d0", 0, {32'd0, rd_data[31:0]}, 64'd0);
    chk("rst_d1", 0, {32'd0, rd_data[63:32]}, 64'd0);
    chk("rst_b", 0, {62'd0, rd_busy}, 64'd0);
    chk("rst_any", 1, {63'd0, any_busy}, 64'd0);
    chk("rst_cnt", 1, {58'd0, busy_cnt}, 64'd0);
    @(negedge CLK);
    idle();
    rst = 1'b1;
    read_all_zero("post");
    #1;
    chk("post_cnt", 0, {58'd0, busy_cnt}, 64'd0);
    chk("post_any", 0, {63'd0, any_busy}, 64'd0);

    // First write lands on the first edge after release
    wa_en = 1'b1; wa_addr = 5'd8; wa_data = 32'h88;
    rd_addr = {5'd0, 5'd8};
    @(negedge CLK);
    idle();
    #1;
    chk("first_wr", 0, {32'd0, rd_data_n[31:0]}, 64'h88);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
